// File: rtl/aoc_stream_pkg.sv
// Shared types for the record sequencer.
//   state_e   : sequencer FSM states
//   len_sat_t : result of len_sat (saturated length plus overflow flag)
//   len_sat   : clamps a raw header length to a maximum and flags overflow
package aoc_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        START,
        READ,
        OUTPUT,
        DONE
    } state_e;

    typedef struct packed {
        logic [31:0] len;
        logic        ovf;
    } len_sat_t;

    function automatic len_sat_t len_sat(input logic [31:0] raw, input logic [31:0] max_len);
        len_sat_t r;
        r.ovf = (raw > max_len);
        r.len = r.ovf ? max_len : raw;
        return r;
    endfunction

endpackage

// File: rtl/vector_record_sequencer.sv
// Sequences an external vector reader over a stream of length-prefixed records.
// Each record is one header beat (length in the low bits) followed by data beats,
// which are passed through to the reader. The reader's vector is then offered
// downstream on a valid/ready handshake together with its record index.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   go                  start pulse (ignored while busy)
//   data_in_*           upstream record stream (slave side)
//   rd_data_*           stream towards the reader (master side)
//   rd_start            one-cycle reader start pulse
//   rd_vec_length       length presented to the reader
//   rd_ready            reader completion pulse
//   rd_last             reader sticky tlast flag
//   rd_vec              reader vector
//   vec_valid/ready     downstream handshake
//   vec_data, vec_index captured vector and its zero-based record index
//   busy, done          pass in progress / stream fully consumed
//   len_err             sticky: a header length exceeded MAX_VEC_LENGTH
//
// state  | meaning
// IDLE   | waiting for go after reset
// HEADER | accepting a header beat
// START  | pulsing rd_start
// READ   | passing data beats through to the reader
// OUTPUT | presenting the captured vector downstream
// DONE   | stream consumed, waiting for go
module vector_record_sequencer
    import aoc_stream_pkg::*;
#(
    parameter int MAX_VEC_LENGTH   = 64,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1),
    parameter int COUNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic                        data_in_tvalid,
    output logic                        data_in_tready,
    input  logic [AXI_DATA_WIDTH-1:0]   data_in_tdata,
    input  logic                        data_in_tlast,
    output logic                        rd_data_tvalid,
    input  logic                        rd_data_tready,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data_tdata,
    output logic                        rd_data_tlast,
    output logic                        rd_start,
    output logic [MAX_VEC_LENGTH_W-1:0] rd_vec_length,
    input  logic                        rd_ready,
    input  logic                        rd_last,
    input  logic [MAX_VEC_LENGTH-1:0]   rd_vec,
    output logic                        vec_valid,
    input  logic                        vec_ready,
    output logic [MAX_VEC_LENGTH-1:0]   vec_data,
    output logic [COUNT_W-1:0]          vec_index,
    output logic                        busy,
    output logic                        done,
    output logic                        len_err
);

    state_e               state, state_next;
    logic [COUNT_W-1:0]   counter;
    logic                 rec_last;
    len_sat_t             hdr;
    logic                 hdr_fire;
    logic                 hdr_zero;

    // Only the low length-field bits of the header beat carry the length.
    assign hdr      = len_sat(32'(data_in_tdata[MAX_VEC_LENGTH_W-1:0]), 32'(MAX_VEC_LENGTH));
    assign hdr_zero = (hdr.len == 32'd0);
    assign hdr_fire = (state == HEADER) && data_in_tvalid;

    // Data and tlast are forwarded unconditionally; only tvalid is gated.
    assign rd_data_tdata = data_in_tdata;
    assign rd_data_tlast = data_in_tlast;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = HEADER;
            HEADER:  if (hdr_fire) begin
                         if (!hdr_zero)         state_next = START;
                         else if (data_in_tlast) state_next = DONE;
                     end
            START:   state_next = READ;
            READ:    if (rd_ready) state_next = OUTPUT;
            OUTPUT:  if (vec_ready) state_next = rec_last ? DONE : HEADER;
            DONE:    if (go) state_next = HEADER;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_in_tready = 1'b0;
        rd_data_tvalid = 1'b0;
        rd_start       = 1'b0;
        vec_valid      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            HEADER: begin
                data_in_tready = 1'b1;
                busy           = 1'b1;
            end
            START: begin
                rd_start = 1'b1;
                busy     = 1'b1;
            end
            READ: begin
                rd_data_tvalid = data_in_tvalid;
                data_in_tready = rd_data_tready;
                busy           = 1'b1;
            end
            OUTPUT: begin
                vec_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter       <= '0;
            len_err       <= 1'b0;
            rd_vec_length <= '0;
            vec_data      <= '0;
            vec_index     <= '0;
            rec_last      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (go) begin
                    counter <= '0;
                    len_err <= 1'b0;
                end
                HEADER: if (hdr_fire) begin
                    if (hdr.ovf)   len_err       <= 1'b1;
                    if (!hdr_zero) rd_vec_length <= hdr.len[MAX_VEC_LENGTH_W-1:0];
                end
                READ: if (rd_ready) begin
                    vec_data  <= rd_vec;
                    rec_last  <= rd_last;
                    vec_index <= counter;
                end
                OUTPUT: if (vec_ready) begin
                    if (counter != '1) counter <= counter + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_record_sequencer.sv
module tb_vector_record_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        data_in_tvalid = 1'b0;
    logic        data_in_tready;
    logic [31:0] data_in_tdata = '0;
    logic        data_in_tlast = 1'b0;
    logic        rd_data_tvalid;
    logic        rd_data_tready;
    logic [31:0] rd_data_tdata;
    logic        rd_data_tlast;
    logic        rd_start;
    logic [6:0]  rd_vec_length;
    logic        rd_ready;
    logic        rd_last;
    logic [63:0] rd_vec;
    logic        vec_valid;
    logic        vec_ready = 1'b1;
    logic [63:0] vec_data;
    logic [15:0] vec_index;
    logic        busy;
    logic        done;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_record_sequencer dut (
        .clk(clk), .rst(rst), .go(go),
        .data_in_tvalid(data_in_tvalid), .data_in_tready(data_in_tready),
        .data_in_tdata(data_in_tdata), .data_in_tlast(data_in_tlast),
        .rd_data_tvalid(rd_data_tvalid), .rd_data_tready(rd_data_tready),
        .rd_data_tdata(rd_data_tdata), .rd_data_tlast(rd_data_tlast),
        .rd_start(rd_start), .rd_vec_length(rd_vec_length),
        .rd_ready(rd_ready), .rd_last(rd_last), .rd_vec(rd_vec),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_data(vec_data), .vec_index(vec_index),
        .busy(busy), .done(done), .len_err(len_err)
    );

    // Behavioural reader: packs 32-bit beats LSB-first until the length is covered.
    logic        m_active;
    int          m_cnt;
    logic [6:0]  m_len;
    logic [63:0] m_acc;
    logic        m_last;

    function automatic logic [63:0] len_mask(input logic [6:0] len);
        logic [63:0] one = 64'd1;
        return (len >= 7'd64) ? '1 : ((one << len) - 64'd1);
    endfunction

    function automatic logic [63:0] pack(input logic [63:0] acc, input logic [31:0] d, input int cnt);
        return acc | (64'(d) << cnt);
    endfunction

    assign rd_data_tready = m_active;

    always @(posedge clk) begin
        rd_ready <= 1'b0;
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_len    <= '0;
            m_acc    <= '0;
            m_last   <= 1'b0;
            rd_last  <= 1'b0;
            rd_vec   <= '0;
        end else if (rd_start) begin
            m_active <= 1'b1;
            m_cnt    <= 0;
            m_acc    <= '0;
            m_last   <= 1'b0;
            m_len    <= rd_vec_length;
        end else if (m_active && rd_data_tvalid && rd_data_tready) begin
            if (m_cnt + 32 >= int'(m_len)) begin
                rd_ready <= 1'b1;
                rd_vec   <= pack(m_acc, rd_data_tdata, m_cnt) & len_mask(m_len);
                rd_last  <= m_last | rd_data_tlast;
                m_active <= 1'b0;
            end else begin
                m_acc  <= pack(m_acc, rd_data_tdata, m_cnt);
                m_cnt  <= m_cnt + 32;
                m_last <= m_last | rd_data_tlast;
            end
        end
    end

    // Accepted downstream vectors and rd_start pulses.
    logic [63:0] q_data[$];
    logic [15:0] q_idx[$];
    int          start_cnt = 0;

    always @(posedge clk) begin
        if (vec_valid && vec_ready) begin
            q_data.push_back(vec_data);
            q_idx.push_back(vec_index);
        end
        if (rd_start) start_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic send_beat(input string tag, input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        data_in_tvalid = 1'b1;
        data_in_tdata  = d;
        data_in_tlast  = l;
        while (!data_in_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, 64'(n), 64'd0);
        @(posedge clk);
        #1;
        data_in_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!vec_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(vec_valid), 64'd1);
    endtask

    task automatic clear_log();
        q_data.delete();
        q_idx.delete();
    endtask

    initial begin
        int s0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tready", 64'(data_in_tready), 64'd0);
        check("rst_vvalid", 64'(vec_valid), 64'd0);
        check("rst_lenerr", 64'(len_err), 64'd0);

        // Test 1: len=40 (2 beats), len=8 (1 beat, tlast)
        clear_log();
        pulse_go();
        check("t1_busy", 64'(busy), 64'd1);
        send_beat("t1_h0", 32'd40, 1'b0);
        send_beat("t1_d0", 32'hDEADBEEF, 1'b0);
        send_beat("t1_d1", 32'h123456A5, 1'b0);
        send_beat("t1_h1", 32'd8, 1'b0);
        send_beat("t1_d2", 32'h0000003C, 1'b1);
        wait_done("t1_done");
        check("t1_count", 64'(q_data.size()), 64'd2);
        check("t1_vec0", q_data[0], 64'h000000A5DEADBEEF);
        check("t1_idx0", 64'(q_idx[0]), 64'd0);
        check("t1_vec1", q_data[1], 64'h000000000000003C);
        check("t1_idx1", 64'(q_idx[1]), 64'd1);
        check("t1_busy_done", 64'(busy), 64'd0);

        // Test 2: same stream, downstream stalls 5 cycles on record 0
        clear_log();
        vec_ready = 1'b0;
        pulse_go();
        send_beat("t2_h0", 32'd40, 1'b0);
        send_beat("t2_d0", 32'hDEADBEEF, 1'b0);
        send_beat("t2_d1", 32'h123456A5, 1'b0);
        wait_valid("t2_valid");
        data_in_tvalid = 1'b1;
        data_in_tdata  = 32'd8;
        data_in_tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_valid", 64'(vec_valid), 64'd1);
            check("t2_hold_data", vec_data, 64'h000000A5DEADBEEF);
            check("t2_hold_tready", 64'(data_in_tready), 64'd0);
        end
        vec_ready = 1'b1;
        send_beat("t2_h1", 32'd8, 1'b0);
        send_beat("t2_d2", 32'h0000003C, 1'b1);
        wait_done("t2_done");
        check("t2_count", 64'(q_data.size()), 64'd2);
        check("t2_vec0", q_data[0], 64'h000000A5DEADBEEF);
        check("t2_vec1", q_data[1], 64'h000000000000003C);
        check("t2_idx1", 64'(q_idx[1]), 64'd1);

        // Test 3: zero-length header is skipped
        clear_log();
        pulse_go();
        send_beat("t3_h0", 32'd0, 1'b0);
        send_beat("t3_h1", 32'd32, 1'b0);
        send_beat("t3_d0", 32'hCAFEF00D, 1'b1);
        wait_done("t3_done");
        check("t3_count", 64'(q_data.size()), 64'd1);
        check("t3_vec0", q_data[0], 64'h00000000CAFEF00D);
        check("t3_idx0", 64'(q_idx[0]), 64'd0);

        // Test 4: oversize header (200 -> field 72) saturates to 64; header tlast ignored
        clear_log();
        pulse_go();
        send_beat("t4_h0", 32'd200, 1'b1);
        check("t4_rd_start", 64'(rd_start), 64'd1);
        check("t4_len", 64'(rd_vec_length), 64'd64);
        check("t4_len_err", 64'(len_err), 64'd1);
        send_beat("t4_d0", 32'h11111111, 1'b0);
        send_beat("t4_d1", 32'h22222222, 1'b1);
        wait_done("t4_done");
        check("t4_count", 64'(q_data.size()), 64'd1);
        check("t4_vec0", q_data[0], 64'h2222222211111111);
        check("t4_len_err_sticky", 64'(len_err), 64'd1);

        // Test 5: tvalid toggling during READ; one rd_start per record
        clear_log();
        pulse_go();
        check("t5_len_err_clr", 64'(len_err), 64'd0);
        check("t5_done_clr", 64'(done), 64'd0);
        s0 = start_cnt;
        send_beat("t5_h0", 32'd64, 1'b0);
        @(negedge clk);
        send_beat("t5_d0", 32'h89ABCDEF, 1'b0);
        @(negedge clk);
        check("t5_rdvalid_gap", 64'(rd_data_tvalid), 64'd0);
        send_beat("t5_d1", 32'h01234567, 1'b1);
        wait_done("t5_done");
        check("t5_starts", 64'(start_cnt - s0), 64'd1);
        check("t5_count", 64'(q_data.size()), 64'd1);
        check("t5_vec0", q_data[0], 64'h0123456789ABCDEF);

        // Test 6: reset mid-READ, then a fresh stream
        clear_log();
        pulse_go();
        send_beat("t6_h0", 32'd64, 1'b0);
        send_beat("t6_d0", 32'hAAAAAAAA, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_tready", 64'(data_in_tready), 64'd0);
        check("t6_rdvalid", 64'(rd_data_tvalid), 64'd0);
        check("t6_vvalid", 64'(vec_valid), 64'd0);
        check("t6_vdata", vec_data, 64'd0);
        pulse_go();
        send_beat("t6_h1", 32'd8, 1'b0);
        send_beat("t6_d1", 32'h0000005A, 1'b1);
        wait_done("t6_done");
        check("t6_count", 64'(q_data.size()), 64'd1);
        check("t6_vec0", q_data[0], 64'h000000000000005A);
        check("t6_idx0", 64'(q_idx[0]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
